// File: rtl/capture_ctrl_pkg.sv
// Shared types and defaults for the camera capture sequencer.
// The frame length default is the same value stat uses.
package capture_ctrl_pkg;

  typedef enum logic [1:0] {
    CAPCTL_IDLE    = 2'd0,
    CAPCTL_ARM     = 2'd1,
    CAPCTL_CAPTURE = 2'd2
  } capctl_state_e;

  localparam int unsigned CAPCTL_TIMEOUT_MS = 200;
  localparam int unsigned BYTE_CNT_W        = 19;

  // 320x240 RGB565 frame
  localparam logic [BYTE_CNT_W-1:0] FRAME_LENGTH_DEF = 19'd153600;

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Camera capture sequencer: arms on start, skips frames, gates href to whole
// frames, reports per-frame length and aborts on a stalled sensor.
//
// state   | meaning
// IDLE    | not capturing; waits for start without stop
// ARM     | waiting for vsync falling edge; counts down skipped frames
// CAPTURE | href passed to the FIFO and counted until vsync rises
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned              CLKFREQ_HZ   = 24000000,
  parameter int unsigned              TIMEOUT_MS   = CAPCTL_TIMEOUT_MS,
  parameter logic [BYTE_CNT_W-1:0]    FRAME_LENGTH = FRAME_LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  href,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [3:0]            skip_frames,
  output logic                  cap_href,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  len_err,
  output logic [BYTE_CNT_W-1:0] cap_bytes,
  output logic [7:0]            frames_captured,
  output logic                  timeout_err
);

  localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLKFREQ_HZ, TIMEOUT_MS);
  localparam int          WD_W        = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  capctl_state_e         state_q, state_d;
  logic                  vsync_d1_q;
  logic                  cont_q, cont_d;
  logic [3:0]            skip_cnt_q, skip_cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  len_err_q, len_err_d;
  logic [BYTE_CNT_W-1:0] cap_bytes_q, cap_bytes_d;
  logic [7:0]            frames_q, frames_d;
  logic                  timeout_err_q, timeout_err_d;

  logic vsync_re, vsync_fe, wd_expired, len_match;

  assign vsync_re   = vsync & ~vsync_d1_q;
  assign vsync_fe   = ~vsync & vsync_d1_q;
  assign wd_expired = (wd_q == '0);
  assign len_match  = (byte_cnt_q == FRAME_LENGTH);

  always_comb begin
    state_d       = state_q;
    cont_d        = cont_q;
    skip_cnt_d    = skip_cnt_q;
    wd_d          = wd_q;
    byte_cnt_d    = byte_cnt_q;
    stop_pend_d   = stop_pend_q;
    frame_done_d  = 1'b0;
    len_err_d     = 1'b0;
    frame_ok_d    = frame_ok_q;
    cap_bytes_d   = cap_bytes_q;
    frames_d      = frames_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      CAPCTL_IDLE: begin
        if (start && !stop) begin
          state_d       = CAPCTL_ARM;
          cont_d        = continuous;
          skip_cnt_d    = skip_frames;
          wd_d          = WD_LOAD;
          timeout_err_d = 1'b0;
          stop_pend_d   = 1'b0;
        end
      end

      CAPCTL_ARM: begin
        if (wd_expired) begin
          state_d       = CAPCTL_IDLE;
          timeout_err_d = 1'b1;
          stop_pend_d   = 1'b0;
        end else if (stop) begin
          state_d = CAPCTL_IDLE;
        end else begin
          wd_d = (vsync_re || vsync_fe) ? WD_LOAD : wd_q - WD_W'(1);
          if (vsync_fe) begin
            if (skip_cnt_q == 4'd0) begin
              state_d    = CAPCTL_CAPTURE;
              byte_cnt_d = '0;
            end else begin
              skip_cnt_d = skip_cnt_q - 4'd1;
            end
          end
        end
      end

      CAPCTL_CAPTURE: begin
        if (wd_expired) begin
          state_d       = CAPCTL_IDLE;
          timeout_err_d = 1'b1;
          stop_pend_d   = 1'b0;
        end else begin
          wd_d = (vsync_re || vsync_fe) ? WD_LOAD : wd_q - WD_W'(1);
          if (href && (byte_cnt_q != '1)) byte_cnt_d = byte_cnt_q + 19'd1;
          if (stop) stop_pend_d = 1'b1;
          if (vsync_re) begin
            frame_done_d = 1'b1;
            cap_bytes_d  = byte_cnt_q;
            frame_ok_d   = len_match;
            len_err_d    = ~len_match;
            frames_d     = frames_q + 8'd1;
            // skip count only ever applies ahead of the first frame
            if (cont_q && !stop_pend_q && !stop) begin
              state_d    = CAPCTL_ARM;
              skip_cnt_d = 4'd0;
              wd_d       = WD_LOAD;
            end else begin
              state_d     = CAPCTL_IDLE;
              stop_pend_d = 1'b0;
            end
          end
        end
      end

      default: state_d = CAPCTL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CAPCTL_IDLE;
      vsync_d1_q    <= 1'b0;
      cont_q        <= 1'b0;
      skip_cnt_q    <= 4'd0;
      wd_q          <= '0;
      byte_cnt_q    <= '0;
      stop_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      len_err_q     <= 1'b0;
      cap_bytes_q   <= '0;
      frames_q      <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_d1_q    <= vsync;
      cont_q        <= cont_d;
      skip_cnt_q    <= skip_cnt_d;
      wd_q          <= wd_d;
      byte_cnt_q    <= byte_cnt_d;
      stop_pend_q   <= stop_pend_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      len_err_q     <= len_err_d;
      cap_bytes_q   <= cap_bytes_d;
      frames_q      <= frames_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cap_href        = href & (state_q == CAPCTL_CAPTURE);
  assign busy            = (state_q != CAPCTL_IDLE);
  assign frame_done      = frame_done_q;
  assign frame_ok        = frame_ok_q;
  assign len_err         = len_err_q;
  assign cap_bytes       = cap_bytes_q;
  assign frames_captured = frames_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: frame-level reference of which frames pass,
// randomized frame sizes, line lengths and blanking.
module tb_capture_ctrl;

  localparam int          CLK_HZ = 1000000;
  localparam int          TO_MS  = 2;
  localparam int          TC     = CLK_HZ / 1000 * TO_MS;
  localparam logic [18:0] FL     = 19'd1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync, href, start, stop, continuous;
  logic [3:0]  skip_frames;
  logic        cap_href, busy, frame_done, frame_ok, len_err, timeout_err;
  logic [18:0] cap_bytes;
  logic [7:0]  frames_captured;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  m_frames = 8'd0;
  logic        s_cap;

  capture_ctrl #(.CLKFREQ_HZ(CLK_HZ), .TIMEOUT_MS(TO_MS), .FRAME_LENGTH(FL)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .start(start), .stop(stop),
    .continuous(continuous), .skip_frames(skip_frames), .cap_href(cap_href),
    .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok), .len_err(len_err),
    .cap_bytes(cap_bytes), .frames_captured(frames_captured), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Frame-level reference: index i counts vsync falling edges after start.
  function automatic bit passes(int i, int skip, bit cont, int stop_fr);
    if (i < skip) return 1'b0;
    if (!cont) return (i == skip);
    return (stop_fr < 0) || (i <= stop_fr);
  endfunction

  function automatic bit busy_after(int i, int skip, bit cont, int stop_fr);
    if (i < skip) return 1'b1;
    return cont && ((stop_fr < 0) || (i < stop_fr));
  endfunction

  // One clock: drive inputs, sample cap_href mid-cycle, return #1 after the edge.
  task automatic cyc(input bit vs, input bit hr, input bit st, input bit sp);
    vsync = vs; href = hr; start = st; stop = sp;
    @(negedge clk);
    s_cap = cap_href;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  // Blanking, falling edge, nbytes of href in random lines, then the rising edge.
  task automatic drive_frame(input int nbytes, input int stop_at,
                             output int o_pass, output int o_leak, output int o_done,
                             output bit o_done_re, output bit o_busy,
                             output logic [18:0] o_bytes, output bit o_ok, output bit o_lerr);
    int sent, left, ln;
    o_pass = 0; o_leak = 0; o_done = 0; sent = 0; left = nbytes;
    repeat ($urandom_range(6, 2)) begin
      cyc(1, 0, 0, 0); o_leak += int'(s_cap); o_done += int'(frame_done);
    end
    cyc(0, 1'($urandom_range(1, 0)), 0, 0); o_leak += int'(s_cap); o_done += int'(frame_done);
    while (left > 0) begin
      ln = $urandom_range(120, 60);
      if (ln > left) ln = left;
      for (int k = 0; k < ln; k++) begin
        cyc(0, 1, 0, sent == stop_at); o_pass += int'(s_cap); o_done += int'(frame_done);
        sent++;
      end
      left -= ln;
      repeat ($urandom_range(4, 1)) begin
        cyc(0, 0, 0, 0); o_leak += int'(s_cap); o_done += int'(frame_done);
      end
    end
    cyc(1, 0, 0, 0);
    o_leak += int'(s_cap); o_done += int'(frame_done);
    o_done_re = frame_done; o_busy = busy; o_bytes = cap_bytes;
    o_ok = frame_ok; o_lerr = len_err;
  endtask

  task automatic test_reset();
    rst = 1'b0; vsync = 1'b1; href = 1'b1; start = 1'b0; stop = 1'b0;
    continuous = 1'b0; skip_frames = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (cap_href !== 1'b0) begin n_fail++; $display("FAIL reset_cap_href got %b exp 0", cap_href); end
    n_tests++; if ({frame_done, frame_ok, len_err, timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {frame_done, frame_ok, len_err, timeout_err}); end
    n_tests++; if (cap_bytes !== 19'd0 || frames_captured !== 8'd0) begin
      n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", cap_bytes, frames_captured); end
    rst = 1'b1;
    cyc(1, 0, 0, 1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_alone_idle got %b exp 0", busy); end
  endtask

  task automatic test_single();
    int p, l, d; bit dre, bz, ok, le; logic [18:0] nb;
    skip_frames = 4'd0; continuous = 1'b0;
    cyc(1, 0, 1, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    drive_frame(int'(FL), -1, p, l, d, dre, bz, nb, ok, le);
    m_frames++;
    n_tests++; if (p != int'(FL) || l != 0) begin n_fail++; $display("FAIL single_pass got %0d/%0d exp %0d/0", p, l, FL); end
    n_tests++; if (d != 1 || dre !== 1'b1) begin n_fail++; $display("FAIL single_done got %0d/%b exp 1/1", d, dre); end
    n_tests++; if (nb !== FL || ok !== 1'b1 || le !== 1'b0) begin
      n_fail++; $display("FAIL single_len got %0d ok=%b le=%b exp %0d ok=1 le=0", nb, ok, le, FL); end
    n_tests++; if (bz !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got %b exp 0", bz); end
    n_tests++; if (frames_captured !== m_frames) begin
      n_fail++; $display("FAIL single_frames got %0d exp %0d", frames_captured, m_frames); end
  endtask

  task automatic test_skip();
    int p, l, d; bit dre, bz, ok, le; logic [18:0] nb;
    skip_frames = 4'd2; continuous = 1'b0;
    cyc(1, 0, 1, 0);
    skip_frames = 4'd0; continuous = 1'b1;
    cyc(1, 0, 1, 0);  // ignored while busy
    for (int i = 0; i < 4; i++) begin
      drive_frame(int'(FL), -1, p, l, d, dre, bz, nb, ok, le);
      if (i == 2) m_frames++;
      n_tests++; if (p != ((i == 2) ? int'(FL) : 0) || l != 0) begin
        n_fail++; $display("FAIL skip_pass[%0d] got %0d/%0d exp %0d/0", i, p, l, (i == 2) ? int'(FL) : 0); end
      n_tests++; if (d != ((i == 2) ? 1 : 0)) begin n_fail++; $display("FAIL skip_done[%0d] got %0d exp %0d", i, d, (i == 2) ? 1 : 0); end
      n_tests++; if (bz !== (i < 2)) begin n_fail++; $display("FAIL skip_busy[%0d] got %b exp %b", i, bz, i < 2); end
    end
    n_tests++; if (frames_captured !== m_frames) begin
      n_fail++; $display("FAIL skip_frames got %0d exp %0d", frames_captured, m_frames); end
  endtask

  task automatic test_continuous();
    int p, l, d; bit dre, bz, ok, le; logic [18:0] nb;
    skip_frames = 4'd0; continuous = 1'b1;
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive_frame(int'(FL), (i == 2) ? int'(FL) / 2 : -1, p, l, d, dre, bz, nb, ok, le);
      if (i < 3) m_frames++;
      n_tests++; if (p != ((i < 3) ? int'(FL) : 0) || l != 0) begin
        n_fail++; $display("FAIL cont_pass[%0d] got %0d/%0d exp %0d/0", i, p, l, (i < 3) ? int'(FL) : 0); end
      n_tests++; if (d != ((i < 3) ? 1 : 0) || dre !== (i < 3)) begin
        n_fail++; $display("FAIL cont_done[%0d] got %0d/%b exp %0d", i, d, dre, (i < 3) ? 1 : 0); end
      n_tests++; if (bz !== (i < 2)) begin n_fail++; $display("FAIL cont_busy[%0d] got %b exp %b", i, bz, i < 2); end
    end
    n_tests++; if (frames_captured !== m_frames) begin
      n_fail++; $display("FAIL cont_frames got %0d exp %0d", frames_captured, m_frames); end
  endtask

  task automatic test_short();
    int p, l, d; bit dre, bz, ok, le; logic [18:0] nb;
    skip_frames = 4'd0; continuous = 1'b0;
    cyc(1, 0, 1, 0);
    drive_frame(1000, -1, p, l, d, dre, bz, nb, ok, le);
    m_frames++;
    n_tests++; if (dre !== 1'b1 || ok !== 1'b0 || le !== 1'b1) begin
      n_fail++; $display("FAIL short_flags got done=%b ok=%b le=%b exp 1/0/1", dre, ok, le); end
    n_tests++; if (nb !== 19'd1000) begin n_fail++; $display("FAIL short_bytes got %0d exp 1000", nb); end
    cyc(1, 0, 0, 0);
    n_tests++; if (len_err !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL short_pulse got le=%b done=%b exp 0/0", len_err, frame_done); end
  endtask

  task automatic test_timeout();
    int n, dn;
    n = 0; dn = 0;
    skip_frames = 4'd1; continuous = 1'b1;
    cyc(1, 0, 1, 0);
    while (busy === 1'b1 && n < 3 * TC) begin
      cyc(1, 0, 0, 0); n++; dn += int'(frame_done);
    end
    n_tests++; if (n != TC) begin n_fail++; $display("FAIL timeout_cycles got %0d exp %0d", n, TC); end
    n_tests++; if (timeout_err !== 1'b1 || dn != 0) begin
      n_fail++; $display("FAIL timeout_err got %b done=%0d exp 1/0", timeout_err, dn); end
    repeat (5) cyc(1, 0, 0, 0);
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b exp 1", timeout_err); end
    cyc(1, 0, 1, 0);
    n_tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clear got err=%b busy=%b exp 0/1", timeout_err, busy); end
    cyc(1, 0, 0, 1);
    n_tests++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL stop_in_arm got busy=%b done=%b exp 0/0", busy, frame_done); end
  endtask

  task automatic test_random();
    int p, l, d, skip, nfr, stop_fr, nb; bit cont, ps, dre, bz, ok, le; logic [18:0] cb;
    for (int run = 0; run < 5; run++) begin
      skip = $urandom_range(2, 0);
      cont = 1'($urandom_range(1, 0));
      nfr = skip + $urandom_range(2, 1);
      stop_fr = -1;
      if (cont && $urandom_range(1, 0) == 1) stop_fr = $urandom_range(nfr - 1, skip);
      skip_frames = 4'(skip); continuous = cont;
      cyc(1, 0, 1, 0);
      skip_frames = 4'($urandom_range(15, 0)); continuous = 1'($urandom_range(1, 0));
      for (int i = 0; i < nfr; i++) begin
        nb = ($urandom_range(1, 0) == 1) ? int'(FL) : $urandom_range(1300, 900);
        ps = passes(i, skip, cont, stop_fr);
        drive_frame(nb, (i == stop_fr) ? nb / 2 : -1, p, l, d, dre, bz, cb, ok, le);
        n_tests++; if (p != (ps ? nb : 0) || l != 0) begin
          n_fail++; $display("FAIL rnd%0d_pass[%0d] got %0d/%0d exp %0d/0", run, i, p, l, ps ? nb : 0); end
        n_tests++; if (d != int'(ps) || dre !== ps) begin
          n_fail++; $display("FAIL rnd%0d_done[%0d] got %0d/%b exp %b", run, i, d, dre, ps); end
        n_tests++; if (bz !== busy_after(i, skip, cont, stop_fr)) begin
          n_fail++; $display("FAIL rnd%0d_busy[%0d] got %b exp %b", run, i, bz, busy_after(i, skip, cont, stop_fr)); end
        if (ps) begin
          m_frames++;
          n_tests++; if (cb !== 19'(nb) || ok !== (nb == int'(FL)) || le !== (nb != int'(FL))) begin
            n_fail++; $display("FAIL rnd%0d_len[%0d] got %0d ok=%b le=%b exp %0d", run, i, cb, ok, le, nb); end
          n_tests++; if (frames_captured !== m_frames) begin
            n_fail++; $display("FAIL rnd%0d_frames got %0d exp %0d", run, frames_captured, m_frames); end
        end
      end
      if (busy_after(nfr - 1, skip, cont, stop_fr)) begin
        cyc(1, 0, 0, 1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_stop got %b exp 0", run, busy); end
      end
    end
  endtask

  task automatic test_corner();
    skip_frames = 4'd0; continuous = 1'b1;
    cyc(1, 0, 1, 1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_same got %b exp 0", busy); end
    cyc(1, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (50) cyc(0, 1, 0, 0);
    n_tests++; if (busy !== 1'b1 || s_cap !== 1'b1) begin
      n_fail++; $display("FAIL precut_capture got busy=%b cap=%b exp 1/1", busy, s_cap); end
    rst = 1'b0; vsync = 1'b0; href = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0 || cap_href !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state got busy=%b cap=%b exp 0/0", busy, cap_href); end
    n_tests++; if ({frame_done, frame_ok, len_err, timeout_err} !== 4'b0 || cap_bytes !== 19'd0 || frames_captured !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs got %b %0d %0d exp 0", {frame_done, frame_ok, len_err, timeout_err}, cap_bytes, frames_captured); end
    rst = 1'b1; m_frames = 8'd0;
    cyc(1, 0, 0, 0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skip();
    test_continuous();
    test_short();
    test_timeout();
    test_random();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
